bytecode_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the Java-bytecode core.
- Fetches opcode and argument bytes from byte-wide program memory and drives the opcode decoder. Uses the decoder outputs (argc, stackargs, stackwb, isaluop, constpush, constval) to sequence operand pops, ALU operations, stack writeback and PC updates.
- Shares one request/acknowledge interface to the operand stack and one start/done interface to the ALU.

---
 rtl/bytecode_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_bytecode_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bytecode_sequencer.sv
// bytecode_sequencer
//   Multi-cycle fetch/decode/execute controller for the Java-bytecode core.
//   Fetches opcode and argument bytes from byte-wide program memory, presents
//   the opcode to an external combinational decoder, then sequences operand
//   pops, an ALU operation, stack writeback and PC updates.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin execution at PC_INIT (IDLE only)
//   prog_rd/prog_addr        program memory read; prog_data valid next cycle
//   dec_*                    opcode out, decoded attributes in
//   pop_req/pop_ack/pop_data stack pop interface
//   push_req/push_ack/...    stack push interface
//   alu_start/alu_done/...   ALU interface, operands on opa/opb
//   cmp_taken                external branch comparator result
//   pc, busy, halted, unsupported, ret_value   status
//
// Handshakes:
//   pop_req / push_req are levels. Once raised they stay high until the
//   matching ack is seen high at a rising edge; that edge completes exactly
//   one transfer (pop_data is sampled on it). A request held high across
//   several acks is several transfers. pop_req and push_req are never high
//   together. alu_start is a single-cycle pulse; alu_done is honoured only
//   while waiting for that ALU operation and ignored at any other time.
module bytecode_sequencer #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] PC_INIT  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                prog_rd,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [7:0]          prog_data,
  output logic [7:0]          dec_opcode,
  input  logic [1:0]          dec_argc,
  input  logic [1:0]          dec_stackargs,
  input  logic                dec_stackwb,
  input  logic                dec_isaluop,
  input  logic                dec_constpush,
  input  logic [31:0]         dec_constval,
  output logic                pop_req,
  input  logic                pop_ack,
  input  logic [31:0]         pop_data,
  output logic                push_req,
  output logic [31:0]         push_data,
  input  logic                push_ack,
  output logic                alu_start,
  output logic [31:0]         opa,
  output logic [31:0]         opb,
  input  logic                alu_done,
  input  logic [31:0]         alu_result,
  input  logic                cmp_taken,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic                unsupported,
  output logic [31:0]         ret_value
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_ARG,
    S_AWAIT,
    S_POP,
    S_EXEC,
    S_AWAIT_ALU,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [7:0] OP_BIPUSH  = 8'h10;
  localparam logic [7:0] OP_SIPUSH  = 8'h11;
  localparam logic [7:0] OP_DUP     = 8'h59;
  localparam logic [7:0] OP_IINC    = 8'h84;
  localparam logic [7:0] OP_GOTO    = 8'ha7;
  localparam logic [7:0] OP_IRETURN = 8'hac;
  localparam logic [7:0] OP_ARETURN = 8'hb0;
  localparam logic [7:0] OP_RETURN  = 8'hb1;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  // FSM state; a plain named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [PC_WIDTH-1:0] ipc;        // address of the current opcode
  logic [7:0]          opcode;
  logic [15:0]         arg;        // argument bytes, big-endian shift-in
  logic [31:0]         result;
  logic [1:0]          argc_q;
  logic [1:0]          stackargs_q;
  logic                stackwb_q;
  logic                isaluop_q;
  logic                constpush_q;
  logic [31:0]         constval_q;
  logic [1:0]          arg_cnt;
  logic [1:0]          pop_cnt;
  logic                push_cnt;   // DUP: first push already done

  logic                op_supported;
  logic                op_ret_value;
  logic                op_cond;
  logic                op_dup;
  logic                op_alu;
  logic [PC_WIDTH-1:0] branch_target;

  function automatic logic is_supported(input logic [7:0] op);
    logic ok;
    ok = 1'b0;
    if (op == 8'h00)                  ok = 1'b1;
    if (op >= 8'h02 && op <= 8'h08)   ok = 1'b1;
    if (op == 8'h10 || op == 8'h11)   ok = 1'b1;
    if (op == 8'h57 || op == 8'h59)   ok = 1'b1;
    if (op >= 8'h60 && op <= 8'h84)   ok = 1'b1;
    if (op >= 8'h99 && op <= 8'ha4)   ok = 1'b1;
    if (op == 8'ha7 || op == 8'hac)   ok = 1'b1;
    if (op == 8'hb0 || op == 8'hb1)   ok = 1'b1;
    return ok;
  endfunction

  assign op_supported  = is_supported(opcode);
  assign op_ret_value  = (opcode == OP_IRETURN) || (opcode == OP_ARETURN);
  assign op_cond       = (opcode >= 8'h99) && (opcode <= 8'ha4);
  assign op_dup        = (opcode == OP_DUP);
  // IINC is flagged as an ALU op by the decoder but is handled without the ALU.
  assign op_alu        = isaluop_q && (opcode != OP_IINC);
  // Branch offsets are signed 16-bit, relative to the opcode address; the
  // cast sign-extends or truncates to the PC width, so wrap is modulo.
  assign branch_target = ipc + PC_WIDTH'($signed(arg));

  assign prog_addr  = pc;
  assign dec_opcode = opcode;
  assign push_data  = result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    prog_rd    = 1'b0;
    pop_req    = 1'b0;
    push_req   = 1'b0;
    alu_start  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        prog_rd    = 1'b1;
        state_next = S_FWAIT;
      end
      S_FWAIT: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Decoder outputs are live here: they follow the opcode register.
        if (!op_supported)             state_next = S_HALT;
        else if (dec_argc != 2'd0)      state_next = S_ARG;
        else if (dec_stackargs != 2'd0) state_next = S_POP;
        else                            state_next = S_EXEC;
      end
      S_ARG: begin
        prog_rd    = 1'b1;
        state_next = S_AWAIT;
      end
      S_AWAIT: begin
        if (arg_cnt + 2'd1 == argc_q) begin
          state_next = (stackargs_q != 2'd0) ? S_POP : S_EXEC;
        end else begin
          state_next = S_ARG;
        end
      end
      S_POP: begin
        pop_req = 1'b1;
        if (pop_ack && (pop_cnt + 2'd1 == stackargs_q)) state_next = S_EXEC;
      end
      S_EXEC: begin
        if (op_ret_value || opcode == OP_RETURN) begin
          state_next = S_HALT;
        end else if (op_alu) begin
          alu_start  = 1'b1;
          state_next = S_AWAIT_ALU;
        end else if (stackwb_q || op_dup) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_AWAIT_ALU: begin
        if (alu_done) state_next = stackwb_q ? S_WB : S_FETCH;
      end
      S_WB: begin
        push_req = 1'b1;
        // DUP needs a second, separate push of the same word.
        if (push_ack && (!op_dup || push_cnt)) state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      ipc         <= '0;
      opcode      <= '0;
      arg         <= '0;
      opa         <= '0;
      opb         <= '0;
      result      <= '0;
      ret_value   <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      unsupported <= 1'b0;
      argc_q      <= '0;
      stackargs_q <= '0;
      stackwb_q   <= 1'b0;
      isaluop_q   <= 1'b0;
      constpush_q <= 1'b0;
      constval_q  <= '0;
      arg_cnt     <= '0;
      pop_cnt     <= '0;
      push_cnt    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc   <= PC_INIT;
            busy <= 1'b1;
          end
        end
        S_FETCH: begin
          ipc <= pc;
        end
        S_FWAIT: begin
          opcode <= prog_data;
          pc     <= pc + PC_ONE;
        end
        S_DECODE: begin
          argc_q      <= dec_argc;
          stackargs_q <= dec_stackargs;
          stackwb_q   <= dec_stackwb;
          isaluop_q   <= dec_isaluop;
          constpush_q <= dec_constpush;
          constval_q  <= dec_constval;
          arg         <= '0;
          arg_cnt     <= '0;
          pop_cnt     <= '0;
          push_cnt    <= 1'b0;
          if (!op_supported) begin
            unsupported <= 1'b1;
            halted      <= 1'b1;
            busy        <= 1'b0;
          end
        end
        S_AWAIT: begin
          arg     <= {arg[7:0], prog_data};
          pc      <= pc + PC_ONE;
          arg_cnt <= arg_cnt + 2'd1;
        end
        S_POP: begin
          if (pop_ack) begin
            if (pop_cnt == 2'd0) opb <= pop_data;
            else                 opa <= pop_data;
            pop_cnt <= pop_cnt + 2'd1;
          end
        end
        S_EXEC: begin
          if (constpush_q)              result <= constval_q;
          else if (opcode == OP_BIPUSH) result <= {{24{arg[7]}}, arg[7:0]};
          else if (opcode == OP_SIPUSH) result <= {{16{arg[15]}}, arg};
          else if (op_dup)              result <= opb;
          // Not-taken branches leave pc at ipc+3, already advanced past args.
          if (opcode == OP_GOTO || (op_cond && cmp_taken)) pc <= branch_target;
          if (op_ret_value) ret_value <= opb;
          if (op_ret_value || opcode == OP_RETURN) begin
            halted <= 1'b1;
            busy   <= 1'b0;
          end
        end
        S_AWAIT_ALU: begin
          if (alu_done) result <= alu_result;
        end
        S_WB: begin
          if (push_ack) push_cnt <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_sequencer.sv
// tb_bytecode_sequencer
//   Directed bench for bytecode_sequencer: program memory, decoder, stack and
//   ALU models around the DUT, followed by a linear sequence of programs whose
//   expected pushes, pops, fetch addresses and status are computed by hand.
module tb_bytecode_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        prog_rd;
  logic [15:0] prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  dec_opcode;
  logic [1:0]  dec_argc;
  logic [1:0]  dec_stackargs;
  logic        dec_stackwb;
  logic        dec_isaluop;
  logic        dec_constpush;
  logic [31:0] dec_constval;
  logic        pop_req;
  logic        pop_ack;
  logic [31:0] pop_data;
  logic        push_req;
  logic [31:0] push_data;
  logic        push_ack;
  logic        alu_start;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        cmp_taken;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
  logic        unsupported;
  logic [31:0] ret_value;

  bytecode_sequencer #(.PC_WIDTH(16), .PC_INIT(16'h0000)) dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
    .dec_opcode(dec_opcode), .dec_argc(dec_argc), .dec_stackargs(dec_stackargs),
    .dec_stackwb(dec_stackwb), .dec_isaluop(dec_isaluop),
    .dec_constpush(dec_constpush), .dec_constval(dec_constval),
    .pop_req(pop_req), .pop_ack(pop_ack), .pop_data(pop_data),
    .push_req(push_req), .push_data(push_data), .push_ack(push_ack),
    .alu_start(alu_start), .opa(opa), .opb(opb),
    .alu_done(alu_done), .alu_result(alu_result), .cmp_taken(cmp_taken),
    .pc(pc), .busy(busy), .halted(halted), .unsupported(unsupported),
    .ret_value(ret_value)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- models ----------------
  logic [7:0]  mem [0:65535];
  logic [31:0] stk [0:15];
  logic [31:0] push_log [0:15];
  logic [15:0] rd_log [0:63];
  logic        clr;
  int          sp, pop_n, push_n, rd_n;
  int          pop_wait, push_wait, pop_delay, push_delay;
  int          pop_req_cyc, push_req_cyc;
  int          alu_delay, alu_wait, alu_starts;
  logic        alu_pend;
  logic [31:0] alu_res, alu_a, alu_b;
  logic        both_req;

  // Decoder model for the opcodes the programs use.
  always_comb begin
    dec_argc      = 2'd0;
    dec_stackargs = 2'd0;
    dec_stackwb   = 1'b0;
    dec_isaluop   = 1'b0;
    dec_constpush = 1'b0;
    dec_constval  = 32'd0;
    if (dec_opcode >= 8'h02 && dec_opcode <= 8'h08) begin
      dec_constpush = 1'b1;
      dec_stackwb   = 1'b1;
      dec_constval  = {24'd0, dec_opcode} - 32'd3;
    end
    case (dec_opcode)
      8'h10: begin dec_argc = 2'd1; dec_stackwb = 1'b1; end
      8'h11: begin dec_argc = 2'd2; dec_stackwb = 1'b1; end
      8'h15: begin dec_argc = 2'd1; dec_stackwb = 1'b1; end
      8'h59: begin dec_stackargs = 2'd1; end
      8'h60: begin dec_stackargs = 2'd2; dec_stackwb = 1'b1; dec_isaluop = 1'b1; end
      8'h99: begin dec_argc = 2'd2; dec_stackargs = 2'd1; end
      8'ha7: begin dec_argc = 2'd2; end
      8'hac: begin dec_stackargs = 2'd1; end
      default: begin end
    endcase
  end

  assign pop_ack    = pop_req && (pop_wait == pop_delay);
  assign push_ack   = push_req && (push_wait == push_delay);
  assign pop_data   = (sp > 0) ? stk[sp-1] : 32'd0;
  assign alu_done   = alu_pend && (alu_wait == 0);
  assign alu_result = alu_res;

  always @(posedge clk) begin
    if (prog_rd) prog_data <= mem[prog_addr];
    if (clr) begin
      sp <= 0; pop_n <= 0; push_n <= 0; rd_n <= 0;
      pop_wait <= 0; push_wait <= 0; pop_req_cyc <= 0; push_req_cyc <= 0;
      alu_pend <= 1'b0; alu_wait <= 0; alu_starts <= 0; both_req <= 1'b0;
    end else begin
      if (pop_req && push_req) both_req <= 1'b1;
      if (prog_rd && rd_n < 64) begin
        rd_log[rd_n] <= prog_addr;
        rd_n <= rd_n + 1;
      end
      if (pop_req) begin
        pop_req_cyc <= pop_req_cyc + 1;
        if (pop_ack) begin
          sp <= sp - 1; pop_n <= pop_n + 1; pop_wait <= 0;
        end else pop_wait <= pop_wait + 1;
      end
      if (push_req) begin
        push_req_cyc <= push_req_cyc + 1;
        if (push_ack) begin
          stk[sp] <= push_data; sp <= sp + 1;
          if (push_n < 16) push_log[push_n] <= push_data;
          push_n <= push_n + 1; push_wait <= 0;
        end else push_wait <= push_wait + 1;
      end
      if (alu_start) begin
        alu_pend <= 1'b1; alu_wait <= alu_delay;
        alu_res <= opa + opb; alu_a <= opa; alu_b <= opb;
        alu_starts <= alu_starts + 1;
      end else if (alu_pend) begin
        if (alu_wait == 0) alu_pend <= 1'b0;
        else alu_wait <= alu_wait - 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[16'hffff] = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int max);
    int n = 0;
    while (!halted && n < max) begin @(negedge clk); n++; end
    check({tag, "_halt_in_time"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_push(input string tag, input int cnt, input int max);
    int n = 0;
    while (push_n < cnt && n < max) begin @(negedge clk); n++; end
    check({tag, "_push_in_time"}, {31'd0, push_n >= cnt}, 32'd1);
  endtask

  task automatic wait_rd(input string tag, input int cnt, input int max);
    int n = 0;
    while (rd_n < cnt && n < max) begin @(negedge clk); n++; end
    check({tag, "_fetch_in_time"}, {31'd0, rd_n >= cnt}, 32'd1);
  endtask

  task automatic load_iadd_prog();
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h06; mem[2] = 8'h60; mem[3] = 8'hac;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; clr = 1'b1; start = 1'b0; cmp_taken = 1'b0;
    pop_delay = 0; push_delay = 0; alu_delay = 0;
    do_reset();

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_unsup", {31'd0, unsupported}, 32'd0);
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_strobes", {28'd0, prog_rd, pop_req, push_req, alu_start}, 32'd0);
    check("rst_ret", ret_value, 32'd0);

    // iconst_2 iconst_3 iadd ireturn
    load_iadd_prog();
    pulse_start();
    wait_halt("iadd", 200);
    check("iadd_push_n", push_n, 3);
    check("iadd_push0", push_log[0], 32'd2);
    check("iadd_push1", push_log[1], 32'd3);
    check("iadd_push2", push_log[2], 32'd5);
    check("iadd_alu_starts", alu_starts, 1);
    check("iadd_alu_a", alu_a, 32'd2);
    check("iadd_alu_b", alu_b, 32'd3);
    check("iadd_pop_n", pop_n, 3);
    check("iadd_ret", ret_value, 32'd5);
    check("iadd_busy", {31'd0, busy}, 32'd0);
    check("iadd_pc", {16'd0, pc}, 32'd4);
    check("iadd_unsup", {31'd0, unsupported}, 32'd0);

    // bipush 0x80, sipush 0x1234, return
    do_reset();
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h80; mem[2] = 8'h11; mem[3] = 8'h12;
    mem[4] = 8'h34; mem[5] = 8'hb1;
    pulse_start();
    wait_push("push1", 1, 100);
    check("bipush_pc", {16'd0, pc}, 32'd2);
    wait_push("push2", 2, 100);
    check("sipush_pc", {16'd0, pc}, 32'd5);
    wait_halt("push", 100);
    check("bipush_val", push_log[0], 32'hffffff80);
    check("sipush_val", push_log[1], 32'h00001234);
    check("push_no_pop", pop_req_cyc, 0);
    check("push_final_pc", {16'd0, pc}, 32'd6);

    // goto -4 at address 4
    do_reset();
    clear_mem();
    mem[4] = 8'ha7; mem[5] = 8'hff; mem[6] = 8'hfc;
    pulse_start();
    wait_rd("goto", 8, 100);
    check("goto_rd4", {16'd0, rd_log[4]}, 32'd4);
    check("goto_rd6", {16'd0, rd_log[6]}, 32'd6);
    check("goto_target", {16'd0, rd_log[7]}, 32'd0);

    // goto -1 to 0xffff, then fetch wraps to 0x0000
    do_reset();
    clear_mem();
    mem[0] = 8'ha7; mem[1] = 8'hff; mem[2] = 8'hff;
    pulse_start();
    wait_rd("wrap", 5, 100);
    check("wrap_rd3", {16'd0, rd_log[3]}, 32'h0000ffff);
    check("wrap_rd4", {16'd0, rd_log[4]}, 32'd0);

    // iconst_0 nop ifeq +8 at address 2, taken then not taken
    for (int t = 1; t >= 0; t--) begin
      do_reset();
      clear_mem();
      mem[0] = 8'h03; mem[2] = 8'h99; mem[3] = 8'h00; mem[4] = 8'h08;
      mem[5] = 8'hb1; mem[10] = 8'hb1;
      cmp_taken = t[0];
      pulse_start();
      wait_halt("ifeq", 200);
      check("ifeq_next_fetch", {16'd0, rd_log[5]}, t ? 32'd10 : 32'd5);
      check("ifeq_final_pc", {16'd0, pc}, t ? 32'd11 : 32'd6);
      check("ifeq_pop_n", pop_n, 1);
    end
    cmp_taken = 1'b0;

    // iadd program with pop_ack delayed by 3 cycles
    do_reset();
    load_iadd_prog();
    pop_delay = 3;
    pulse_start();
    wait_halt("slowpop", 400);
    check("slowpop_req_cyc", pop_req_cyc, 12);
    check("slowpop_pop_n", pop_n, 3);
    check("slowpop_alu_starts", alu_starts, 1);
    check("slowpop_ret", ret_value, 32'd5);
    pop_delay = 0;

    // iconst_2 dup ireturn with push_ack delayed by 2 cycles
    do_reset();
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h59; mem[2] = 8'hac;
    push_delay = 2;
    pulse_start();
    wait_halt("dup", 400);
    check("dup_push_n", push_n, 3);
    check("dup_push1", push_log[1], 32'd2);
    check("dup_push2", push_log[2], 32'd2);
    check("dup_req_cyc", push_req_cyc, 9);
    check("dup_pop_n", pop_n, 2);
    check("dup_ret", ret_value, 32'd2);
    check("dup_no_overlap", {31'd0, both_req}, 32'd0);
    push_delay = 0;

    // reset while waiting on a slow ALU
    do_reset();
    load_iadd_prog();
    alu_delay = 40;
    pulse_start();
    begin
      int n = 0;
      while (alu_starts < 1 && n < 100) begin @(negedge clk); n++; end
      check("midrst_alu_started", {31'd0, alu_starts >= 1}, 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_pc", {16'd0, pc}, 32'd0);
    check("midrst_strobes", {28'd0, prog_rd, pop_req, push_req, alu_start}, 32'd0);
    check("midrst_opa", opa, 32'd0);
    check("midrst_opb", opb, 32'd0);
    check("midrst_push_data", push_data, 32'd0);
    check("midrst_opcode", {24'd0, dec_opcode}, 32'd0);
    repeat (50) @(negedge clk);
    check("midrst_stray_done", {29'd0, busy, halted, push_req}, 32'd0);
    alu_delay = 0;

    // unsupported opcode 0x15
    do_reset();
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h07;
    pulse_start();
    wait_halt("unsup", 100);
    check("unsup_flag", {31'd0, unsupported}, 32'd1);
    check("unsup_busy", {31'd0, busy}, 32'd0);
    check("unsup_fetches", rd_n, 1);
    check("unsup_activity", pop_req_cyc + push_req_cyc + alu_starts, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    check("unsup_start_ignored", {15'd0, halted, pc}, {15'd0, 1'b1, 16'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
